// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the game sequencer and its consumers (the
// seven-segment display controller decodes the same state encodings).
//   game_state_t           : 3-bit game state encoding
//   DEFAULT_FRAMES_PER_SEC : clk_game cycles per second (60 Hz frame tick)
package game_pkg;

  typedef enum logic [2:0] {
    STATE_MENU      = 3'b000,
    STATE_COUNTDOWN = 3'b001,
    STATE_GAMEPLAY  = 3'b010,
    STATE_GAME_OVER = 3'b011
  } game_state_t;

  localparam int DEFAULT_FRAMES_PER_SEC = 60;

endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect
// Rising-edge detector for a debounced, synchronous button level.
// The previous-sample register resets to 1 so a button that is already
// held when reset releases does not produce a press.
//   clk_game : game clock
//   reset    : asynchronous, active-high
//   level    : button level
//   press    : high for the cycle in which level rises (level & ~prev)
module btn_edge_detect (
  input  logic clk_game,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic prev;

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      prev <= 1'b1;
    end else begin
      prev <= level;
    end
  end

  // Combinational so the press acts on the same edge that samples it.
  assign press = level & ~prev;

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller
// Master game sequencer: MENU -> COUNTDOWN -> GAMEPLAY -> GAME_OVER -> MENU,
// timed from the frame clock. All outputs are registered.
//   clk_game           : 60 Hz game clock
//   reset              : asynchronous, active-high
//   btn_start/btn_mode : debounced synchronous button levels
//   p1_ko/p2_ko        : player health reached zero (levels)
//   current_game_state : 000 MENU, 001 COUNTDOWN, 010 GAMEPLAY, 011 GAME_OVER
//   game_mode_1p       : 1 = one-player mode
//   game_time_seconds  : elapsed gameplay seconds (never above MAX_GAME_SECS)
//   winner_p1/winner_p2/game_is_draw : round result, only set in GAME_OVER
//   countdown_value    : seconds remaining in the countdown
//   gameplay_active    : high only in GAMEPLAY
module game_flow_controller
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = DEFAULT_FRAMES_PER_SEC,
  parameter int COUNTDOWN_SECS = 3,
  parameter int MAX_GAME_SECS  = 99
) (
  input  logic       clk_game,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       p1_ko,
  input  logic       p2_ko,
  output logic [2:0] current_game_state,
  output logic       game_mode_1p,
  output logic [7:0] game_time_seconds,
  output logic       winner_p1,
  output logic       winner_p2,
  output logic       game_is_draw,
  output logic [1:0] countdown_value,
  output logic       gameplay_active
);

  localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAMES_PER_SEC - 1);
  localparam logic [FC_W-1:0] FRAME_ONE  = FC_W'(1);
  localparam logic [1:0]      CD_INIT    = 2'(COUNTDOWN_SECS);
  localparam logic [7:0]      TIME_MAX   = 8'(MAX_GAME_SECS);

  game_state_t     state;
  logic [FC_W-1:0] frame_cnt;
  logic            frame_wrap;
  logic [7:0]      time_inc;
  logic            start_press;
  logic            mode_press;
  logic            any_ko;

  btn_edge_detect u_start_edge (
    .clk_game (clk_game),
    .reset    (reset),
    .level    (btn_start),
    .press    (start_press)
  );

  btn_edge_detect u_mode_edge (
    .clk_game (clk_game),
    .reset    (reset),
    .level    (btn_mode),
    .press    (mode_press)
  );

  assign frame_wrap         = (frame_cnt == FRAME_LAST);
  assign time_inc           = game_time_seconds + 8'd1;
  assign any_ko             = p1_ko | p2_ko;
  assign current_game_state = state;

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      state             <= STATE_MENU;
      game_mode_1p      <= 1'b0;
      game_time_seconds <= 8'd0;
      winner_p1         <= 1'b0;
      winner_p2         <= 1'b0;
      game_is_draw      <= 1'b0;
      countdown_value   <= CD_INIT;
      gameplay_active   <= 1'b0;
      frame_cnt         <= '0;
    end else begin
      case (state)
        STATE_MENU: begin
          // Start takes priority over a simultaneous mode press.
          if (start_press) begin
            state             <= STATE_COUNTDOWN;
            frame_cnt         <= '0;
            game_time_seconds <= 8'd0;
            winner_p1         <= 1'b0;
            winner_p2         <= 1'b0;
            game_is_draw      <= 1'b0;
            countdown_value   <= CD_INIT;
          end else if (mode_press) begin
            game_mode_1p <= ~game_mode_1p;
          end
        end

        STATE_COUNTDOWN: begin
          if (frame_wrap) begin
            frame_cnt <= '0;
            // Last second expired: countdown_value is left at 1.
            if (countdown_value == 2'd1) begin
              state           <= STATE_GAMEPLAY;
              gameplay_active <= 1'b1;
            end else begin
              countdown_value <= countdown_value - 2'd1;
            end
          end else begin
            frame_cnt <= frame_cnt + FRAME_ONE;
          end
        end

        STATE_GAMEPLAY: begin
          // KO wins over the frame tick: time freezes on the KO cycle.
          if (any_ko) begin
            game_is_draw    <= p1_ko & p2_ko;
            winner_p1       <= p2_ko & ~p1_ko;
            winner_p2       <= p1_ko & ~p2_ko;
            state           <= STATE_GAME_OVER;
            gameplay_active <= 1'b0;
          end else if (frame_wrap) begin
            frame_cnt         <= '0;
            game_time_seconds <= time_inc;
            if (time_inc == TIME_MAX) begin
              game_is_draw    <= 1'b1;
              state           <= STATE_GAME_OVER;
              gameplay_active <= 1'b0;
            end
          end else begin
            frame_cnt <= frame_cnt + FRAME_ONE;
          end
        end

        STATE_GAME_OVER: begin
          if (start_press) begin
            state             <= STATE_MENU;
            game_time_seconds <= 8'd0;
            winner_p1         <= 1'b0;
            winner_p2         <= 1'b0;
            game_is_draw      <= 1'b0;
            countdown_value   <= CD_INIT;
            frame_cnt         <= '0;
          end
        end

        default: begin
          // Illegal encoding: recover to a clean MENU.
          state             <= STATE_MENU;
          game_time_seconds <= 8'd0;
          winner_p1         <= 1'b0;
          winner_p2         <= 1'b0;
          game_is_draw      <= 1'b0;
          countdown_value   <= CD_INIT;
          gameplay_active   <= 1'b0;
          frame_cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller
// Directed bench for game_flow_controller. Instance u_dut uses default
// parameters; instance u_dut_short uses MAX_GAME_SECS = 3 to reach the
// time-limit draw quickly. Inputs change 1 time unit after a rising edge
// and outputs are checked at the same point.
module tb_game_flow_controller;

  logic clk_game = 1'b0;
  always #5 clk_game = ~clk_game;

  // Default-parameter instance
  logic       reset, btn_start, btn_mode, p1_ko, p2_ko;
  logic [2:0] state;
  logic       mode_1p, win1, win2, draw, active;
  logic [7:0] tsec;
  logic [1:0] cd;

  // MAX_GAME_SECS = 3 instance
  logic       b_reset, b_btn_start, b_btn_mode;
  logic [2:0] b_state;
  logic       b_mode_1p, b_win1, b_win2, b_draw, b_active;
  logic [7:0] b_tsec;
  logic [1:0] b_cd;

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  game_flow_controller u_dut (
    .clk_game           (clk_game),
    .reset              (reset),
    .btn_start          (btn_start),
    .btn_mode           (btn_mode),
    .p1_ko              (p1_ko),
    .p2_ko              (p2_ko),
    .current_game_state (state),
    .game_mode_1p       (mode_1p),
    .game_time_seconds  (tsec),
    .winner_p1          (win1),
    .winner_p2          (win2),
    .game_is_draw       (draw),
    .countdown_value    (cd),
    .gameplay_active    (active)
  );

  game_flow_controller #(.MAX_GAME_SECS(3)) u_dut_short (
    .clk_game           (clk_game),
    .reset              (b_reset),
    .btn_start          (b_btn_start),
    .btn_mode           (b_btn_mode),
    .p1_ko              (1'b0),
    .p2_ko              (1'b0),
    .current_game_state (b_state),
    .game_mode_1p       (b_mode_1p),
    .game_time_seconds  (b_tsec),
    .winner_p1          (b_win1),
    .winner_p2          (b_win2),
    .game_is_draw       (b_draw),
    .countdown_value    (b_cd),
    .gameplay_active    (b_active)
  );

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_game);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [2:0] st,
                              input logic [7:0] t, input logic w1,
                              input logic w2, input logic dr);
    check_vec({tag, " state"}, 32'(state), 32'(st));
    check_vec({tag, " time"},  32'(tsec),  32'(t));
    check_vec({tag, " win1"},  32'(win1),  32'(w1));
    check_vec({tag, " win2"},  32'(win2),  32'(w2));
    check_vec({tag, " draw"},  32'(draw),  32'(dr));
  endtask

  initial begin
    reset = 1'b1; btn_start = 1'b1; btn_mode = 1'b0; p1_ko = 1'b0; p2_ko = 1'b0;
    b_reset = 1'b1; b_btn_start = 1'b0; b_btn_mode = 1'b0;
    tick(2);

    // Reset values
    check_result("reset", 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_vec("reset countdown", 32'(cd), 32'd3);
    check_vec("reset mode", 32'(mode_1p), 32'd0);
    check_vec("reset active", 32'(active), 32'd0);

    // Start held through reset release must not fire
    reset = 1'b0;
    tick(10);
    check_vec("held start state", 32'(state), 32'd0);
    btn_start = 1'b0;
    tick(1);
    btn_start = 1'b1;
    tick(1);
    check_vec("fresh start state", 32'(state), 32'd1);
    check_vec("fresh start countdown", 32'(cd), 32'd3);

    // Asynchronous reset mid-countdown, checked before any clock edge
    reset = 1'b1;
    #1;
    check_vec("async reset state", 32'(state), 32'd0);
    btn_start = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);

    // Mode toggling in MENU
    for (int i = 0; i < 3; i++) begin
      btn_mode = 1'b1; tick(1);
      btn_mode = 1'b0; tick(1);
      check_vec($sformatf("mode after %0d", i + 1), 32'(mode_1p), 32'((i + 1) % 2));
    end

    // Simultaneous press: start wins, mode unchanged
    btn_mode = 1'b1; btn_start = 1'b1;
    tick(1);
    check_vec("both press state", 32'(state), 32'd1);
    check_vec("both press mode", 32'(mode_1p), 32'd1);
    btn_mode = 1'b0; btn_start = 1'b0;

    // Countdown 3,2,1 then GAMEPLAY exactly 180 edges after entry
    tick(59);  check_vec("cd 59", 32'(cd), 32'd3);
    tick(1);   check_vec("cd 60", 32'(cd), 32'd2);
    tick(59);  check_vec("cd 119", 32'(cd), 32'd2);
    tick(1);   check_vec("cd 120", 32'(cd), 32'd1);
    tick(59);  check_vec("cd 179 state", 32'(state), 32'd1);
    check_vec("cd 179 active", 32'(active), 32'd0);
    tick(1);   check_vec("cd 180 state", 32'(state), 32'd2);
    check_vec("cd 180 active", 32'(active), 32'd1);
    check_vec("cd 180 countdown", 32'(cd), 32'd1);

    // p2 KO after 310 gameplay cycles: winner p1 at 5 s
    tick(310);
    check_vec("play 310 time", 32'(tsec), 32'd5);
    p2_ko = 1'b1;
    tick(1);
    p2_ko = 1'b0;
    check_result("p2 ko", 3'd3, 8'd5, 1'b1, 1'b0, 1'b0);
    check_vec("p2 ko active", 32'(active), 32'd0);

    // GAME_OVER ignores mode, start returns to MENU keeping mode
    btn_mode = 1'b1; tick(1); btn_mode = 1'b0; tick(1);
    check_vec("over mode ignored", 32'(mode_1p), 32'd1);
    check_vec("over result held", 32'(win1), 32'd1);
    btn_start = 1'b1;
    tick(1);
    check_result("back to menu", 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_vec("back to menu mode", 32'(mode_1p), 32'd1);
    check_vec("back to menu countdown", 32'(cd), 32'd3);
    btn_start = 1'b0;
    tick(1);

    // Second round: KO ignored in countdown, double KO on wrap at 7 s
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    p1_ko = 1'b1;
    tick(179);
    check_vec("ko in countdown ignored", 32'(state), 32'd1);
    p1_ko = 1'b0;
    tick(1);
    check_vec("round2 gameplay", 32'(state), 32'd2);
    tick(479);
    check_vec("play 479 time", 32'(tsec), 32'd7);
    p1_ko = 1'b1; p2_ko = 1'b1;
    tick(1);
    p1_ko = 1'b0; p2_ko = 1'b0;
    check_result("double ko on wrap", 3'd3, 8'd7, 1'b0, 1'b0, 1'b1);

    // Time-limit instance: set 1P mode, play to MAX_GAME_SECS = 3
    b_reset = 1'b0;
    tick(2);
    b_btn_mode = 1'b1; tick(1); b_btn_mode = 1'b0; tick(1);
    b_btn_start = 1'b1;
    tick(1);
    b_btn_start = 1'b0;
    check_vec("short countdown", 32'(b_state), 32'd1);
    tick(180);
    check_vec("short gameplay", 32'(b_state), 32'd2);
    tick(179);
    check_vec("short 179 time", 32'(b_tsec), 32'd2);
    check_vec("short 179 draw", 32'(b_draw), 32'd0);
    tick(1);
    check_vec("limit time", 32'(b_tsec), 32'd3);
    check_vec("limit draw", 32'(b_draw), 32'd1);
    check_vec("limit state", 32'(b_state), 32'd3);
    check_vec("limit win1", 32'(b_win1), 32'd0);
    check_vec("limit active", 32'(b_active), 32'd0);
    tick(30);
    check_vec("limit time held", 32'(b_tsec), 32'd3);
    b_btn_start = 1'b1;
    tick(1);
    b_btn_start = 1'b0;
    check_vec("limit to menu state", 32'(b_state), 32'd0);
    check_vec("limit to menu time", 32'(b_tsec), 32'd0);
    check_vec("limit to menu draw", 32'(b_draw), 32'd0);
    check_vec("limit to menu mode", 32'(b_mode_1p), 32'd1);
    check_vec("limit to menu countdown", 32'(b_cd), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
